sram_port_arbiter: RTL and testbench

- Parametrised N-client arbiter for the single shared 16-bit async SRAM.
- Generalises the fixed Delay→Loop token hand-off into request/grant/done handshakes.
- Supports round-robin or fixed priority, per-client enable masks, a hold-time watchdog and registered read-data return.
- Sits between the effect chain clients (delay, looper, future reverb/sampler) and the top-level SRAM pad logic; runs on the BCLK domain.

---
 rtl/sram_arb_pkg.sv | 31 +++
 rtl/sram_port_arbiter_rr_select.sv | 21 ++
 rtl/sram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Holds the FSM state type and the rotating-priority search.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    // Lowest offset from the start index wins; start is ptr+1 in rr mode.
    function automatic int rr_pick(
        input logic [7:0] elig,
        input int         ptr,
        input logic       rr_en,
        input int         n
    );
        int start;
        int k;
        rr_pick = 0;
        start   = rr_en ? (ptr + 1) % n : 0;
        for (int i = 7; i >= 0; i--) begin
            k = (start + i) % n;
            if (i < n && elig[k]) rr_pick = k;
        end
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_select.sv
// Combinational rotating-priority picker.
// Produces a one-hot winner and its index from the eligible set.
module rr_select
    import sram_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        idx    = IDX_W'(rr_pick(8'(eligible), int'(ptr), rr_en, N));
        winner = (|eligible) ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// N-client arbiter for the shared async SRAM: grant/done handshake,
// hold watchdog, turnaround cycle and registered read return.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_HOLD  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_rr_en,
    input  logic [N_CLIENTS-1:0]        i_client_en,
    input  logic [N_CLIENTS-1:0]        i_req,
    input  logic [N_CLIENTS-1:0]        i_done,
    input  logic [N_CLIENTS*ADDR_W-1:0] i_addr,
    input  logic [N_CLIENTS-1:0]        i_we_n,
    input  logic [N_CLIENTS*DATA_W-1:0] i_wdata,
    output logic [N_CLIENTS-1:0]        o_gnt,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [N_CLIENTS-1:0]        o_rvalid,
    output logic [N_CLIENTS-1:0]        o_err_timeout,
    input  logic                        i_clr_err,
    output logic [ADDR_W-1:0]           o_sram_addr,
    output logic                        o_sram_we_n,
    output logic [DATA_W-1:0]           o_sram_wdata,
    output logic                        o_sram_dq_oe,
    input  logic [DATA_W-1:0]           i_sram_rdata
);

    localparam int IDX_W  = $clog2(N_CLIENTS);
    localparam int HOLD_W = $clog2(MAX_HOLD);

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     gidx;
    logic [IDX_W-1:0]     win_idx;
    logic [N_CLIENTS-1:0] eligible;
    logic [N_CLIENTS-1:0] win;
    logic [N_CLIENTS-1:0] err_base;
    logic [HOLD_W-1:0]    hold;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    g_addr;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    g_wdata;
    logic                 g_we_n;
    logic                 in_grant;
    logic                 release_g;
    logic                 hold_max;

    assign eligible = i_req & i_client_en;

    rr_select #(
        .N     (N_CLIENTS),
        .IDX_W (IDX_W)
    ) u_sel (
        .eligible (eligible),
        .ptr      (ptr),
        .rr_en    (i_rr_en),
        .winner   (win),
        .idx      (win_idx)
    );

    assign g_addr    = i_addr[int'(gidx)*ADDR_W +: ADDR_W];
    assign g_wdata   = i_wdata[int'(gidx)*DATA_W +: DATA_W];
    assign g_we_n    = i_we_n[gidx];
    assign in_grant  = (state == S_GRANT);
    // Dropping req or enable mid-grant releases the bus like done.
    assign release_g = i_done[gidx] | ~eligible[gidx];
    assign hold_max  = (hold == HOLD_W'(MAX_HOLD - 1));
    assign err_base  = i_clr_err ? '0 : o_err_timeout;

    assign o_sram_addr  = in_grant ? g_addr : addr_q;
    assign o_sram_wdata = in_grant ? g_wdata : wdata_q;
    assign o_sram_dq_oe = in_grant & ~g_we_n;
    assign o_sram_we_n  = ~(in_grant & ~g_we_n);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            gidx          <= '0;
            hold          <= '0;
            o_gnt         <= '0;
            o_rdata       <= '0;
            o_rvalid      <= '0;
            o_err_timeout <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            o_rvalid      <= '0;
            o_err_timeout <= err_base;
            unique case (state)
                S_IDLE: begin
                    if (|eligible) begin
                        o_gnt <= win;
                        gidx  <= win_idx;
                        hold  <= '0;
                        if (i_rr_en) ptr <= win_idx;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    addr_q  <= g_addr;
                    wdata_q <= g_wdata;
                    if (g_we_n) begin
                        o_rdata  <= i_sram_rdata;
                        o_rvalid <= o_gnt;
                    end
                    if (release_g) begin
                        o_gnt <= '0;
                        state <= S_TURN;
                    end else if (hold_max) begin
                        o_gnt         <= '0;
                        o_err_timeout <= err_base | o_gnt;
                        state         <= S_TURN;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                S_TURN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: vector table plus
// hand-written read/write/watchdog/reset sequences.
module tb_sram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 16;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_rr_en;
    logic [N-1:0]  i_client_en;
    logic [N-1:0]  i_req;
    logic [N-1:0]  i_done;
    logic [N*AW-1:0] i_addr;
    logic [N-1:0]  i_we_n;
    logic [N*DW-1:0] i_wdata;
    logic [N-1:0]  o_gnt;
    logic [DW-1:0] o_rdata;
    logic [N-1:0]  o_rvalid;
    logic [N-1:0]  o_err_timeout;
    logic          i_clr_err;
    logic [AW-1:0] o_sram_addr;
    logic          o_sram_we_n;
    logic [DW-1:0] o_sram_wdata;
    logic          o_sram_dq_oe;
    logic [DW-1:0] i_sram_rdata;

    sram_port_arbiter #(
        .N_CLIENTS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_HOLD  (16)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_rr_en       (i_rr_en),
        .i_client_en   (i_client_en),
        .i_req         (i_req),
        .i_done        (i_done),
        .i_addr        (i_addr),
        .i_we_n        (i_we_n),
        .i_wdata       (i_wdata),
        .o_gnt         (o_gnt),
        .o_rdata       (o_rdata),
        .o_rvalid      (o_rvalid),
        .o_err_timeout (o_err_timeout),
        .i_clr_err     (i_clr_err),
        .o_sram_addr   (o_sram_addr),
        .o_sram_we_n   (o_sram_we_n),
        .o_sram_wdata  (o_sram_wdata),
        .o_sram_dq_oe  (o_sram_dq_oe),
        .i_sram_rdata  (i_sram_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] en;
        logic [3:0] done;
        logic       rr;
        logic [3:0] gnt;
        logic [3:0] rv;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic add(input logic [3:0] req, input logic [3:0] en,
                       input logic [3:0] done, input logic rr,
                       input logic [3:0] gnt, input logic [3:0] rv);
        vec_t v;
        v.req  = req;
        v.en   = en;
        v.done = done;
        v.rr   = rr;
        v.gnt  = gnt;
        v.rv   = rv;
        tbl.push_back(v);
    endtask

    initial begin
        int n;
        logic [3:0] c1h;

        // Fixed priority, stray done, release via req drop and enable drop.
        add(4'b1010, 4'b1111, 4'b0000, 1'b0, 4'b0010, 4'b0000);
        add(4'b1010, 4'b1111, 4'b0001, 1'b0, 4'b0010, 4'b0010);
        add(4'b1000, 4'b1111, 4'b0010, 1'b0, 4'b0000, 4'b0010);
        add(4'b1000, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        add(4'b1000, 4'b1111, 4'b0000, 1'b0, 4'b1000, 4'b0000);
        add(4'b1000, 4'b1111, 4'b0000, 1'b0, 4'b1000, 4'b1000);
        add(4'b0000, 4'b1111, 4'b1000, 1'b0, 4'b0000, 4'b1000);
        add(4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        add(4'b0010, 4'b1101, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        add(4'b0010, 4'b1101, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        add(4'b0010, 4'b1111, 4'b0000, 1'b0, 4'b0010, 4'b0000);
        add(4'b0010, 4'b1101, 4'b0000, 1'b0, 4'b0000, 4'b0010);
        add(4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        // Round robin: park ptr on client 3, then all four contend.
        add(4'b1000, 4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b0000);
        add(4'b0000, 4'b1111, 4'b1000, 1'b1, 4'b0000, 4'b1000);
        add(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            c1h = 4'b0001 << (k % 4);
            add(4'b1111, 4'b1111, 4'b0000, 1'b1, c1h, 4'b0000);
            add(4'b1111, 4'b1111, 4'b0000, 1'b1, c1h, c1h);
            add(4'b1111, 4'b1111, 4'b0000, 1'b1, c1h, c1h);
            add(4'b1111, 4'b1111, c1h, 1'b1, 4'b0000, c1h);
            add(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        end
        add(4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000);

        i_rst_n      = 1'b0;
        i_rr_en      = 1'b0;
        i_client_en  = 4'b1111;
        i_req        = '0;
        i_done       = '0;
        i_we_n       = 4'b1111;
        i_clr_err    = 1'b0;
        i_sram_rdata = 16'hA5A5;
        for (int i = 0; i < N; i++) begin
            i_addr[i*AW +: AW]  = AW'(20'h00100 + i);
            i_wdata[i*DW +: DW] = DW'(16'h5000 + i);
        end
        i_addr[2*AW +: AW]  = 20'h00123;
        i_wdata[0*DW +: DW] = 16'h1234;

        repeat (3) tick();
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_rvalid", 32'(o_rvalid), 32'h0);
        chk("rst_rdata", 32'(o_rdata), 32'h0);
        chk("rst_err", 32'(o_err_timeout), 32'h0);
        chk("rst_addr", 32'(o_sram_addr), 32'h0);
        chk("rst_we_n", 32'(o_sram_we_n), 32'h1);
        chk("rst_wdata", 32'(o_sram_wdata), 32'h0);
        chk("rst_oe", 32'(o_sram_dq_oe), 32'h0);
        i_rst_n = 1'b1;
        tick();

        foreach (tbl[r]) begin
            i_req       = tbl[r].req;
            i_client_en = tbl[r].en;
            i_done      = tbl[r].done;
            i_rr_en     = tbl[r].rr;
            tick();
            chk($sformatf("vec%0d_gnt", r), 32'(o_gnt), 32'(tbl[r].gnt));
            chk($sformatf("vec%0d_rv", r), 32'(o_rvalid), 32'(tbl[r].rv));
        end
        i_done  = '0;
        i_rr_en = 1'b0;

        // Read path on client 2.
        i_req = 4'b0100;
        tick();
        chk("rd_gnt", 32'(o_gnt), 32'h4);
        chk("rd_addr", 32'(o_sram_addr), 32'h00123);
        chk("rd_oe", 32'(o_sram_dq_oe), 32'h0);
        chk("rd_we_n", 32'(o_sram_we_n), 32'h1);
        i_sram_rdata = 16'hBEEF;
        tick();
        chk("rd_data", 32'(o_rdata), 32'hBEEF);
        chk("rd_rvalid", 32'(o_rvalid), 32'h4);
        chk("rd_oe2", 32'(o_sram_dq_oe), 32'h0);
        i_req  = '0;
        i_done = 4'b0100;
        tick();
        i_done = '0;
        chk("rd_rel_gnt", 32'(o_gnt), 32'h0);
        tick();

        // Write path on client 0.
        i_we_n = 4'b1110;
        i_req  = 4'b0001;
        tick();
        chk("wr_gnt", 32'(o_gnt), 32'h1);
        chk("wr_we_n", 32'(o_sram_we_n), 32'h0);
        chk("wr_oe", 32'(o_sram_dq_oe), 32'h1);
        chk("wr_wdata", 32'(o_sram_wdata), 32'h1234);
        chk("wr_addr", 32'(o_sram_addr), 32'h00100);
        tick();
        chk("wr_no_rvalid", 32'(o_rvalid), 32'h0);
        i_req  = '0;
        i_done = 4'b0001;
        tick();
        i_done = '0;
        chk("wr_rel_gnt", 32'(o_gnt), 32'h0);
        chk("wr_rel_rvalid", 32'(o_rvalid), 32'h0);
        chk("turn_we_n", 32'(o_sram_we_n), 32'h1);
        chk("turn_oe", 32'(o_sram_dq_oe), 32'h0);
        chk("turn_addr_held", 32'(o_sram_addr), 32'h00100);
        tick();
        i_we_n = 4'b1111;

        // Watchdog on client 3.
        i_req = 4'b1000;
        tick();
        chk("wd_gnt", 32'(o_gnt), 32'h8);
        n = 0;
        while (o_gnt != 0 && n < 40) begin
            tick();
            n++;
        end
        i_req = '0;
        chk("wd_cycles", 32'(n), 32'd16);
        chk("wd_err", 32'(o_err_timeout), 32'h8);
        tick();

        // Timeout of client 1 coinciding with clear: new bit survives.
        i_req = 4'b0010;
        tick();
        repeat (15) tick();
        chk("clr_race_pre", 32'(o_gnt), 32'h2);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        i_req     = '0;
        chk("clr_race_gnt", 32'(o_gnt), 32'h0);
        chk("clr_race_err", 32'(o_err_timeout), 32'h2);
        tick();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("clr_err", 32'(o_err_timeout), 32'h0);

        // Done on the last allowed cycle counts as done, no error.
        i_req = 4'b1000;
        tick();
        repeat (15) tick();
        chk("edge_pre", 32'(o_gnt), 32'h8);
        i_req  = '0;
        i_done = 4'b1000;
        tick();
        i_done = '0;
        chk("edge_gnt", 32'(o_gnt), 32'h0);
        chk("edge_err", 32'(o_err_timeout), 32'h0);
        tick();

        // Async reset in the middle of a write grant.
        i_we_n = 4'b1110;
        i_req  = 4'b0001;
        tick();
        chk("rstw_we_n_pre", 32'(o_sram_we_n), 32'h0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rstw_we_n", 32'(o_sram_we_n), 32'h1);
        chk("rstw_oe", 32'(o_sram_dq_oe), 32'h0);
        chk("rstw_gnt", 32'(o_gnt), 32'h0);
        i_req = '0;
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("rstw_after", 32'(o_gnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
